// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: transfer sizes, FSM states and
// the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled little-endian load value.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_size)
      SIZE_B:  o_data = {{24{~i_unsigned & i_data[7]}}, i_data[7:0]};
      SIZE_H:  o_data = {{16{~i_unsigned & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: splits byte/half/word requests into
// little-endian single-byte memory accesses and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  state_t                r_state, w_state_next;
  logic                  r_we, r_unsigned, r_err;
  logic [1:0]            r_size, r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, r_rbuf, r_rdata;
  logic                  w_last;
  logic [31:0]           w_rbuf_next, w_ext;

  assign w_last = ({1'b0, r_cnt} == (size_bytes(r_size) - 3'd1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_next = (req_size == 2'b11) ? RESP : XFER;
      XFER:    if (w_last) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Merge the byte arriving this cycle so the final byte can feed the
  // extender and the result register on the same edge.
  always_comb begin
    w_rbuf_next = r_rbuf;
    w_rbuf_next[8*r_cnt +: 8] = mem_data_out;
  end

  lsu_extend u_extend (
    .i_data     (w_rbuf_next),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rbuf     <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_we       <= req_we;
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_addr     <= req_addr;
          r_wdata    <= req_wdata;
          r_cnt      <= '0;
          r_rbuf     <= '0;
          r_rdata    <= '0;
          r_err      <= (req_size == 2'b11);
        end
        XFER: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we) r_rbuf <= w_rbuf_next;
          if (w_last) r_rdata <= r_we ? '0 : w_ext;
        end
        RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign resp_valid  = (r_state == RESP);
  assign resp_err    = (r_state == RESP) & r_err;
  assign resp_rdata  = r_rdata;
  assign mem_we      = (r_state == XFER) & r_we;
  assign mem_addr    = (r_state == XFER) ? r_addr + ADDR_WIDTH'(r_cnt) : '0;
  assign mem_data_in = ((r_state == XFER) && r_we) ? r_wdata[8*r_cnt +: 8] : '0;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the byte-wide `DATA_MEMORY` port. It accepts one byte, halfword or word load/store request at a time and sequences it into single-byte memory accesses in little-endian order. For loads it assembles the bytes and returns a sign- or zero-extended 32-bit result. It sits between the execute stage and `DATA_MEMORY`, and drives that memory's `addr`, `data_in` and `we` pins.

## Interface
- `ADDR_WIDTH`, default 32: width of the request address and of the memory address.
- `DATA_WIDTH`, default 8: memory data width. Only 8 is supported.
- `clk`  in  1  rising-edge clock shared with `DATA_MEMORY`.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and accepting a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  transfer size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_WIDTH  byte address of the lowest byte.
- `req_wdata`  in  32  store data. Bits [8·N-1:0] are used, where N is the byte count.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  set with `resp_valid` when `req_size`=11.
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`.
- `mem_data_in`  out  DATA_WIDTH  to memory `data_in`.
- `mem_we`  out  1  to memory `we`.
- `mem_data_out`  in  DATA_WIDTH  from memory `data_out`. Valid combinationally in the same cycle as `mem_addr`.

## Operation
- States: IDLE, XFER, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_size`, `req_unsigned`, `req_addr` and `req_wdata`, and clear the byte counter `cnt`.
  - Legal size: go to XFER. Size 11: go to RESP with error flag set and no memory access.
- XFER
  - `mem_addr` = latched address + `cnt`, computed modulo 2^ADDR_WIDTH, so 0xFFFFFFFF+1 wraps to 0.
  - Store: `mem_we`=1 and `mem_data_in` = latched `wdata[8·cnt+7:8·cnt]`.
  - Load: `mem_we`=0, and `mem_data_out` is captured into byte lane `cnt` at the clock edge.
  - `cnt` increments each cycle. After byte N-1 (N = 1, 2 or 4), go to RESP.
  - Misaligned addresses are legal; no alignment check is made.
- RESP
  - `resp_valid`=1 for exactly one cycle, with `resp_rdata` and `resp_err` valid in that cycle. Next state is IDLE.
- Extension for loads: byte uses bit 7 and half uses bit 15 as the sign when `req_unsigned`=0; upper bits are zero when `req_unsigned`=1. Word passes through unchanged.
- `req_ready`=0 in XFER and RESP. A `req_valid` seen in those states is ignored, not queued. The requester does not need to hold request fields after acceptance.
- `mem_we` is asserted only in XFER for stores; there are no spurious writes in any other state.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_data_in`=0.
- Reset asserted mid-XFER forces `mem_we` low immediately, without waiting for a clock edge. Bytes already written stay written, and no response is produced.
- Latency from the acceptance edge to the `resp_valid` cycle is N+1 cycles: byte 2, half 3, word 5, error 1. Accept-to-accept throughput is N+2 cycles.
- A new request can be accepted in the cycle after the `resp_valid` cycle.
- `mem_*` outputs are combinational from registered state only, with no path from `req_*`. `resp_rdata` is registered.

## Structure
- Package `lsu_pkg`:
  - size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`;
  - state enum IDLE/XFER/RESP;
  - function returning the byte count N from the size.
- Sub-module `lsu_extend`: combinational sign/zero extension of the assembled 32-bit value using size and unsigned flag. Instantiated once at the RESP output register.

## Test plan
- Store word: addr 0x10, wdata 0xDEADBEEF -> `mem_we`=1 for 4 cycles with addresses 0x10..0x13 and data EF, BE, AD, DE. `resp_valid` 5 cycles after accept, with `resp_rdata`=0.
- Load byte, signed versus unsigned: memory[0x20]=0x80 -> `resp_rdata`=0xFFFFFF80 when signed and 0x00000080 when unsigned, each 2 cycles after accept.
- Misaligned halfword at 0x21: memory 0x21=0x34, 0x22=0x12, signed -> `resp_rdata`=0x00001234. Then memory 0x22=0x92 gives 0xFFFF9234.
- Address wrap: word load at 0xFFFFFFFE -> `mem_addr` sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- `req_size`=11 with `req_we`=1 -> no `mem_we` pulse; `resp_valid`=1 with `resp_err`=1 one cycle after accept.
- Reset after the 2nd byte of a word store -> `mem_we` drops immediately; only bytes 0 and 1 are modified; `req_ready`=1 and `resp_valid`=0. A `req_valid` held high during XFER is not accepted until IDLE.
